iq_dispatch_ctrl: RTL

- Controller that drains the in-order instruction queue into the OoO backend.
- Tracks per-functional-unit reservation-station credits and decides when to pulse the queue's read enable.
- Tags each dequeued slot with a dispatch-valid bit and back-pressures the decoders when the queue is full.
- Handles pipeline flushes: aborts in-flight reads and restores credits.

---
 rtl/iq_dispatch_ctrl_pkg.sv | 60 ++++++
 rtl/iq_dispatch_ctrl_if.sv | 47 ++++
 rtl/iq_credit_counter.sv | 47 ++++
 rtl/iq_dispatch_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/iq_dispatch_ctrl_pkg.sv
// Shared definitions for the instruction-queue dispatch controller.
// Holds the sizing constants, the FSM state encodings, the functional-unit
// code names, the response payload struct and small helper functions.
// Optional feature macro used by the slice: IQ_DISPATCH_PERF_EN.
package iq_dispatch_ctrl_pkg;

    localparam int unsigned funcUnitCodeSize = 3;
    localparam int unsigned numFuncUnits     = 2 ** funcUnitCodeSize;
    localparam int unsigned creditWidth      = 4;
    localparam int unsigned creditInit       = 8;
    localparam int unsigned perfCounterWidth = 32;
    localparam int unsigned numSlots         = 4;
    localparam int unsigned consumeWidth     = 3;
    // A read may land all slots on one unit, so every counter must cover a full read.
    localparam int unsigned creditGate       = numSlots;

    // FSM state encodings (debug-visible on state_o)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    // Functional-unit codes as presented by the queue
    typedef enum logic [funcUnitCodeSize-1:0] {
        FU_INT0  = 3'd0,
        FU_INT1  = 3'd1,
        FU_MUL   = 3'd2,
        FU_DIV   = 3'd3,
        FU_LOAD  = 3'd4,
        FU_STORE = 3'd5,
        FU_BRANCH = 3'd6,
        FU_FP    = 3'd7
    } fuName_e;

    typedef logic [funcUnitCodeSize-1:0] fuCode_t;
    typedef logic [creditWidth-1:0]      credit_t;

    // Queue response payload; funcUnit[0] belongs to slot 1
    typedef struct packed {
        logic [1:0]                 numInstructions;
        fuCode_t [numSlots-1:0]     funcUnit;
    } queueSlots_t;

    // Contiguous slot mask from slot 1 for (numInstM1 + 1) instructions
    function automatic logic [numSlots-1:0] slotMask(input logic [1:0] numInstM1);
        logic [numSlots-1:0] mask;
        case (numInstM1)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [2:0] popCount4(input logic [numSlots-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/iq_dispatch_ctrl_if.sv
// Queue/backend handshake bundle for iq_dispatch_ctrl.
// master: controller view (drives readEnable_o, dispatchValid_o, decodeStall_o, state_o).
// slave : environment view (drives queue status, FU codes, credit returns, flush).
// With IQ_DISPATCH_PERF_EN defined, stallCycles_o and dispatchedCount_o are added.
interface iq_dispatch_ctrl_if;
    import iq_dispatch_ctrl_pkg::*;

    logic                        isEmpty_i;
    logic                        isFull_i;
    logic                        outputEnable_i;
    logic [1:0]                  numInstructions_i;
    fuCode_t                     inst1FuncUnit_i;
    fuCode_t                     inst2FuncUnit_i;
    fuCode_t                     inst3FuncUnit_i;
    fuCode_t                     inst4FuncUnit_i;
    logic [numFuncUnits-1:0]     creditReturn_i;
    logic                        flush_i;
    logic                        readEnable_o;
    logic [numSlots-1:0]         dispatchValid_o;
    logic                        decodeStall_o;
    logic [1:0]                  state_o;
`ifdef IQ_DISPATCH_PERF_EN
    logic [perfCounterWidth-1:0] stallCycles_o;
    logic [perfCounterWidth-1:0] dispatchedCount_o;
`endif

    modport master (
        input  isEmpty_i, isFull_i, outputEnable_i, numInstructions_i,
        input  inst1FuncUnit_i, inst2FuncUnit_i, inst3FuncUnit_i, inst4FuncUnit_i,
        input  creditReturn_i, flush_i,
        output readEnable_o, dispatchValid_o, decodeStall_o, state_o
`ifdef IQ_DISPATCH_PERF_EN
        , output stallCycles_o, dispatchedCount_o
`endif
    );

    modport slave (
        output isEmpty_i, isFull_i, outputEnable_i, numInstructions_i,
        output inst1FuncUnit_i, inst2FuncUnit_i, inst3FuncUnit_i, inst4FuncUnit_i,
        output creditReturn_i, flush_i,
        input  readEnable_o, dispatchValid_o, decodeStall_o, state_o
`ifdef IQ_DISPATCH_PERF_EN
        , input stallCycles_o, dispatchedCount_o
`endif
    );

endinterface

// File: rtl/iq_credit_counter.sv
// Saturating reservation-station credit counter for one functional unit.
// Ports: clock_i/reset_i (sync, active high), creditReturn (one entry freed),
// consume (entries taken this cycle, 0..4), restore (reload to creditInit),
// count (registered credit value).
module iq_credit_counter
    import iq_dispatch_ctrl_pkg::*;
(
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    creditReturn,
    input  logic [consumeWidth-1:0] consume,
    input  logic                    restore,
    output credit_t                 count
);

    // One extra bit so cur + return can exceed the ceiling before clamping
    localparam int unsigned sumWidth = creditWidth + 1;
    localparam logic [sumWidth-1:0] ceiling = sumWidth'(creditInit);

    logic [sumWidth-1:0] gross;
    logic [sumWidth-1:0] netCount;
    credit_t             countNext;

    // Net the return against consumption first, then clamp at the ceiling
    always_comb begin
        gross     = sumWidth'(count) + sumWidth'(creditReturn);
        netCount  = '0;
        countNext = count;
        if (gross >= sumWidth'(consume)) begin
            netCount = gross - sumWidth'(consume);
        end
        if (restore || (netCount > ceiling)) begin
            countNext = creditWidth'(creditInit);
        end else begin
            countNext = creditWidth'(netCount);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count <= creditWidth'(creditInit);
        end else begin
            count <= countNext;
        end
    end

endmodule

// File: rtl/iq_dispatch_ctrl.sv
// Drains the in-order instruction queue into the out-of-order backend.
// A read is issued only when every functional unit can absorb a full
// four-slot read; the queue answers one cycle later and the dispatched
// slots are flagged on dispatchValid_o the cycle after that.
// Ports: clock_i, reset_i (sync, active high), bus (iq_dispatch_ctrl_if.master):
//   queue status/response and credit returns/flush in; readEnable_o,
//   dispatchValid_o, state_o (registered) and decodeStall_o (combinational) out.
// Optional: IQ_DISPATCH_PERF_EN adds stallCycles_o and dispatchedCount_o.
module iq_dispatch_ctrl
    import iq_dispatch_ctrl_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    iq_dispatch_ctrl_if.master bus
);

    logic [1:0]              state;
    logic [1:0]              nextState;
    logic                    readEnable;
    logic                    readEnableNext;
    logic [numSlots-1:0]     dispatchValid;
    logic [numSlots-1:0]     dispatchNext;
    logic                    creditOk;
    queueSlots_t             resp;
    credit_t                 creditCount  [numFuncUnits];
    logic [consumeWidth-1:0] consumeCount [numFuncUnits];

    assign resp = {bus.numInstructions_i,
                   bus.inst4FuncUnit_i, bus.inst3FuncUnit_i,
                   bus.inst2FuncUnit_i, bus.inst1FuncUnit_i};

    // Read gate: every unit must hold enough credits for a worst-case read
    always_comb begin
        creditOk = 1'b1;
        for (int unsigned n = 0; n < numFuncUnits; n++) begin
            if (creditCount[n] < creditWidth'(creditGate)) begin
                creditOk = 1'b0;
            end
        end
    end

    // Next state and next registered outputs; flush overrides everything
    always_comb begin
        nextState      = state;
        dispatchNext   = '0;
        readEnableNext = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.isEmpty_i && creditOk) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                nextState = RESP;
            end
            RESP: begin
                nextState = IDLE;
                if (bus.outputEnable_i) begin
                    dispatchNext = slotMask(resp.numInstructions);
                end
            end
            FLUSH: begin
                if (!bus.flush_i) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (bus.flush_i) begin
            nextState    = FLUSH;
            dispatchNext = '0;
        end
        readEnableNext = (nextState == REQ);
    end

    // Per-unit consumption: count dispatched slots targeting each unit
    always_comb begin
        for (int unsigned n = 0; n < numFuncUnits; n++) begin
            consumeCount[n] = '0;
            for (int unsigned k = 0; k < numSlots; k++) begin
                if (dispatchNext[k] && (resp.funcUnit[k] == funcUnitCodeSize'(n))) begin
                    consumeCount[n] = consumeCount[n] + consumeWidth'(1);
                end
            end
        end
    end

    for (genvar n = 0; n < numFuncUnits; n++) begin : gCredit
        iq_credit_counter uCounter (
            .clock_i      (clock_i),
            .reset_i      (reset_i),
            .creditReturn (bus.creditReturn_i[n]),
            .consume      (consumeCount[n]),
            .restore      (bus.flush_i),
            .count        (creditCount[n])
        );
    end

    // State and registered outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= IDLE;
            readEnable    <= 1'b0;
            dispatchValid <= '0;
        end else begin
            state         <= nextState;
            readEnable    <= readEnableNext;
            dispatchValid <= dispatchNext;
        end
    end

    assign bus.readEnable_o    = readEnable;
    assign bus.dispatchValid_o = dispatchValid;
    assign bus.state_o         = state;
    assign bus.decodeStall_o   = bus.isFull_i | (state == FLUSH);

`ifdef IQ_DISPATCH_PERF_EN
    logic [perfCounterWidth-1:0] stallCycles;
    logic [perfCounterWidth-1:0] dispatchedCount;

    // Free-running, wrapping counters; flush leaves them alone
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stallCycles     <= '0;
            dispatchedCount <= '0;
        end else begin
            if ((state == IDLE) && !bus.isEmpty_i && !creditOk) begin
                stallCycles <= stallCycles + perfCounterWidth'(1);
            end
            dispatchedCount <= dispatchedCount + perfCounterWidth'(popCount4(dispatchValid));
        end
    end

    assign bus.stallCycles_o     = stallCycles;
    assign bus.dispatchedCount_o = dispatchedCount;
`endif

endmodule
